// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory path: default RAM geometry and the
// encoding used to tag which requester owns an in-flight read.
package cpu_mem_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_IF   = 2'b01,
        OWN_LS   = 2'b10
    } own_t;

endpackage

// File: rtl/ram_port_arbiter.sv
// Arbitrates the single-port RAM between instruction fetch and load/store,
// and steers the registered read data back to whoever issued the read.
module ram_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int MAX_LS_RUN = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    localparam int                RUN_W   = $clog2(MAX_LS_RUN + 1);
    localparam logic [RUN_W-1:0]  RUN_MAX = RUN_W'(MAX_LS_RUN);

    logic [RUN_W-1:0] ls_run;
    logic             fetch_ok;
    logic             grant_ls;
    logic             grant_if;
    own_t             rsp_own;
    own_t             rsp_own_next;

    // Load/store wins unless it has already taken MAX_LS_RUN slots while fetch waited.
    // Grants are gated by reset so nothing reaches the RAM while the core is held.
    always_comb begin
        fetch_ok = if_req && !if_flush;
        grant_ls = reset && ls_req && (!fetch_ok || (ls_run < RUN_MAX));
        grant_if = reset && !grant_ls && fetch_ok;
    end

    assign if_gnt = grant_if;
    assign ls_gnt = grant_ls;

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (grant_ls) begin
            ram_en    = 1'b1;
            ram_we    = ls_we;
            ram_addr  = ls_addr;
            ram_wdata = ls_wdata;
        end else if (grant_if) begin
            ram_en    = 1'b1;
            ram_addr  = if_addr;
        end
    end

    // Run length counts only while fetch is actually asking; any idle fetch cycle resets it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ls_run <= '0;
        end else if (!if_req || grant_if) begin
            ls_run <= '0;
        end else if (grant_ls && (ls_run != RUN_MAX)) begin
            ls_run <= ls_run + RUN_W'(1);
        end
    end

    always_comb begin
        rsp_own_next = OWN_NONE;
        if (grant_if) begin
            rsp_own_next = OWN_IF;
        end else if (grant_ls && !ls_we) begin
            rsp_own_next = OWN_LS;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_own <= OWN_NONE;
        end else begin
            rsp_own <= rsp_own_next;
        end
    end

    // A flush arriving in the response cycle squashes the fetched word; loads are never squashed.
    assign if_rvalid = (rsp_own == OWN_IF) && !if_flush;
    assign ls_rvalid = (rsp_own == OWN_LS);
    assign if_rdata  = ram_rdata;
    assign ls_rdata  = ram_rdata;
    assign busy      = (rsp_own != OWN_NONE);

endmodule
